avr_xmem_fifo: RTL and testbench

- Memory-mapped slave on the AVR core's external data-memory port, decoded by the `sram_address` window.
- Provides a byte TX FIFO (CPU to fabric) and a byte RX FIFO (fabric to CPU), plus status, level and IRQ-mask registers.
- Drives the wait line so that every CPU read takes exactly one wait state.
- Fabric side is two valid/ready byte streams feeding the GD-ROM datapath.

---
 rtl/avr_xmem_fifo.sv | 186 ++++++++++++++++++
 tb/tb_avr_xmem_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avr_xmem_fifo.sv
// AVR external-memory slave: byte TX/RX FIFOs with status, level and IRQ-mask registers.
// CPU writes complete with no wait state; every CPU read is stretched by exactly one WAIT cycle.
module avr_xmem_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] xm_adr,
  input  logic [7:0] xm_din,
  output logic [7:0] xm_dout,
  input  logic       xm_cs,
  input  logic       xm_oe,
  input  logic       xm_we,
  output logic       xm_wait,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      tx_mem_q [DEPTH];
  logic [7:0]      tx_mem_d [DEPTH];
  logic [7:0]      rx_mem_q [DEPTH];
  logic [7:0]      rx_mem_d [DEPTH];
  logic [PW-1:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PW-1:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [LW-1:0]   tx_lvl_q, tx_lvl_d, rx_lvl_q, rx_lvl_d;
  logic            tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
  logic [1:0]      irqen_q, irqen_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [7:0]      dout_q, dout_d;
  logic            irq_q, irq_d;

  logic            tx_full, tx_empty, rx_full, rx_empty;
  logic            wr_acc, rd_req, rd_fire;
  logic            tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0]      status_val, level_val, rd_val;

  // Decode of the current access and FIFO handshakes, all judged on pre-edge state.
  always_comb begin
    tx_full    = (tx_lvl_q == LW'(DEPTH));
    tx_empty   = (tx_lvl_q == LW'(0));
    rx_full    = (rx_lvl_q == LW'(DEPTH));
    rx_empty   = (rx_lvl_q == LW'(0));
    wr_acc     = (state_q == ST_IDLE) && xm_cs && xm_we;
    rd_req     = (state_q == ST_IDLE) && xm_cs && xm_oe && !xm_we;
    rd_fire    = (state_q == ST_WAIT);
    tx_push    = wr_acc && (xm_adr == 2'd0) && !tx_full;
    tx_pop     = !tx_empty && tx_ready;
    rx_push    = rx_valid && !rx_full;
    rx_pop     = rd_fire && (xm_adr == 2'd0) && !rx_empty;
    status_val = {2'b00, rx_unf_q, tx_ovf_q, rx_full, rx_empty, tx_empty, tx_full};
    level_val  = {4'(rx_lvl_q), 4'(tx_lvl_q)};
    case (xm_adr)
      2'd0:    rd_val = rx_empty ? 8'h00 : rx_mem_q[rx_rd_q];
      2'd1:    rd_val = status_val;
      2'd2:    rd_val = level_val;
      2'd3:    rd_val = {6'b000000, irqen_q};
      default: rd_val = 8'h00;
    endcase
  end

  // Next-state logic for the access FSM, registers and both FIFOs.
  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_acc) begin
          state_d = ST_ACK;
        end else if (rd_req) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        state_d = ST_ACK;
        rdata_d = rd_val;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (wr_acc && (xm_adr == 2'd0) && tx_full) begin
      tx_ovf_d = 1'b1;
    end else if (wr_acc && (xm_adr == 2'd1) && xm_din[4]) begin
      tx_ovf_d = 1'b0;
    end else begin
      tx_ovf_d = tx_ovf_q;
    end

    if (rd_fire && (xm_adr == 2'd0) && rx_empty) begin
      rx_unf_d = 1'b1;
    end else if (wr_acc && (xm_adr == 2'd1) && xm_din[5]) begin
      rx_unf_d = 1'b0;
    end else begin
      rx_unf_d = rx_unf_q;
    end

    irqen_d = (wr_acc && (xm_adr == 2'd3)) ? xm_din[1:0] : irqen_q;

    if (tx_push) begin
      tx_mem_d[tx_wr_q] = xm_din;
    end else begin
      tx_mem_d[tx_wr_q] = tx_mem_q[tx_wr_q];
    end
    if (rx_push) begin
      rx_mem_d[rx_wr_q] = rx_data;
    end else begin
      rx_mem_d[rx_wr_q] = rx_mem_q[rx_wr_q];
    end

    tx_wr_d  = tx_push ? tx_wr_q + PW'(1) : tx_wr_q;
    tx_rd_d  = tx_pop  ? tx_rd_q + PW'(1) : tx_rd_q;
    rx_wr_d  = rx_push ? rx_wr_q + PW'(1) : rx_wr_q;
    rx_rd_d  = rx_pop  ? rx_rd_q + PW'(1) : rx_rd_q;
    tx_lvl_d = tx_lvl_q + LW'(tx_push) - LW'(tx_pop);
    rx_lvl_d = rx_lvl_q + LW'(rx_push) - LW'(rx_pop);

    // Read data is only driven onto the bus during ACK.
    dout_d = (state_d == ST_ACK) ? rdata_d : 8'h00;
    irq_d  = (irqen_q[0] && !rx_empty) || (irqen_q[1] && tx_empty);
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tx_mem_q <= '{default: 8'h00};
      rx_mem_q <= '{default: 8'h00};
      tx_wr_q  <= PW'(0);
      tx_rd_q  <= PW'(0);
      rx_wr_q  <= PW'(0);
      rx_rd_q  <= PW'(0);
      tx_lvl_q <= LW'(0);
      rx_lvl_q <= LW'(0);
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
      irqen_q  <= 2'b00;
      rdata_q  <= 8'h00;
      dout_q   <= 8'h00;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_mem_q <= tx_mem_d;
      rx_mem_q <= rx_mem_d;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      tx_lvl_q <= tx_lvl_d;
      rx_lvl_q <= rx_lvl_d;
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
      irqen_q  <= irqen_d;
      rdata_q  <= rdata_d;
      dout_q   <= dout_d;
      irq_q    <= irq_d;
    end
  end

  assign xm_wait  = rd_req || (state_q == ST_WAIT);
  assign xm_dout  = dout_q;
  assign tx_data  = tx_mem_q[tx_rd_q];
  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;
  assign irq      = irq_q;

endmodule

// File: tb/tb_avr_xmem_fifo.sv
// Randomised scoreboard bench for avr_xmem_fifo: a queue-based reference model predicts
// read data, TX stream order, wait timing, status/level and irq.
module tb_avr_xmem_fifo;
  localparam int DL    = 3;
  localparam int DEPTH = 1 << DL;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] xm_adr;
  logic [7:0] xm_din, xm_dout;
  logic       xm_cs, xm_oe, xm_we, xm_wait;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, irq;

  avr_xmem_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .xm_adr(xm_adr), .xm_din(xm_din), .xm_dout(xm_dout),
    .xm_cs(xm_cs), .xm_oe(xm_oe), .xm_we(xm_we), .xm_wait(xm_wait),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int fab_mode = 0;  // 0 manual, 1 random, 2 rx always valid + tx always ready

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] exp_tx_q[$];
  bit         m_ovf, m_unf, irq_exp;
  logic [1:0] m_irqen;
  int         phase;  // bus protocol position: 0 idle, 1 wait-state, 2 ack

  // Model: evaluated once per cycle on pre-edge values, predicting the coming clock edge.
  always @(negedge clk) begin
    int txn, rxn;
    bit exp_wait, wr_push, rd_pop;
    logic [7:0] val;
    if (rst) begin
      chk("rst_wait", xm_wait, 1'b0);
      chk("rst_dout", xm_dout, 8'h00);
      chk("rst_tx_valid", tx_valid, 1'b0);
      chk("rst_rx_ready", rx_ready, 1'b1);
      chk("rst_irq", irq, 1'b0);
      tx_q.delete(); rx_q.delete(); exp_rd_q.delete(); exp_tx_q.delete();
      m_ovf = 0; m_unf = 0; m_irqen = 2'b00; irq_exp = 0; phase = 0;
    end else begin
      txn = tx_q.size();
      rxn = rx_q.size();
      exp_wait = (phase == 0 && xm_cs && xm_oe && !xm_we) || phase == 1;
      chk("tx_valid", tx_valid, txn > 0);
      chk("rx_ready", rx_ready, rxn < DEPTH);
      chk("irq", irq, irq_exp);
      chk("xm_wait", xm_wait, exp_wait);
      if (phase != 2) chk("dout_idle", xm_dout, 8'h00);
      irq_exp = (m_irqen[0] && rxn > 0) || (m_irqen[1] && txn == 0);
      wr_push = 0;
      rd_pop  = 0;
      if (phase == 0 && xm_cs && xm_we) begin
        case (xm_adr)
          2'd0: if (txn == DEPTH) m_ovf = 1; else wr_push = 1;
          2'd1: begin if (xm_din[4]) m_ovf = 0; if (xm_din[5]) m_unf = 0; end
          2'd3: m_irqen = xm_din[1:0];
          default: ;
        endcase
        phase = 2;
      end else if (phase == 0 && xm_cs && xm_oe) begin
        phase = 1;
      end else if (phase == 1) begin
        case (xm_adr)
          2'd0: if (rxn == 0) begin val = 8'h00; m_unf = 1; end
                else begin val = rx_q[0]; rd_pop = 1; end
          2'd1: val = {2'b00, m_unf, m_ovf, rxn == DEPTH, rxn == 0, txn == 0, txn == DEPTH};
          2'd2: val = {4'(rxn), 4'(txn)};
          default: val = {6'b000000, m_irqen};
        endcase
        exp_rd_q.push_back(val);
        phase = 2;
      end else if (phase == 2) begin
        phase = 0;
      end
      if (tx_ready && txn > 0) void'(tx_q.pop_front());
      if (wr_push) begin tx_q.push_back(xm_din); exp_tx_q.push_back(xm_din); end
      if (rd_pop) void'(rx_q.pop_front());
      if (rx_valid && rxn < DEPTH) rx_q.push_back(rx_data);
    end
  end

  // Monitor: compares DUT outputs against scoreboard entries when the DUT presents them.
  int  wcnt = 0;
  bit  prev_wait = 0;
  always @(negedge clk) begin
    if (rst) begin
      wcnt = 0; prev_wait = 0;
    end else begin
      if (xm_wait) wcnt++;
      else if (prev_wait) begin
        chk("wait_len", wcnt, 2);
        if (exp_rd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_data", xm_dout, exp_rd_q.pop_front());
        wcnt = 0;
      end
      prev_wait = xm_wait;
      if (tx_valid && tx_ready) begin
        if (exp_tx_q.size() == 0) chk("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
        else chk("tx_data", tx_data, exp_tx_q.pop_front());
      end
    end
  end

  // Fabric traffic generator for the automatic modes.
  always @(posedge clk) begin
    #1;
    case (fab_mode)
      1: begin tx_ready = 1'($urandom_range(0, 1)); rx_valid = 1'($urandom_range(0, 1)); rx_data = 8'($urandom); end
      2: begin tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'($urandom); end
      default: ;
    endcase
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d, input bit both = 0);
    @(posedge clk); #1;
    xm_cs = 1; xm_we = 1; xm_oe = both; xm_adr = a; xm_din = d;
    repeat (2) @(posedge clk);
    #1;
    xm_cs = 0; xm_we = 0; xm_oe = 0;
  endtask

  task automatic cpu_read(input logic [1:0] a);
    @(posedge clk); #1;
    xm_cs = 1; xm_oe = 1; xm_we = 0; xm_adr = a;
    repeat (3) @(posedge clk);
    #1;
    xm_cs = 0; xm_oe = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick(2);
    rst = 0;
  endtask

  initial begin
    rst = 1; xm_adr = 2'd0; xm_din = 8'h00; xm_cs = 0; xm_oe = 0; xm_we = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 8'h00;
    tick(3);
    rst = 0;

    // Reset values
    cpu_read(2'd1);
    cpu_read(2'd2);

    // TX overflow: ninth write dropped; drain shows original order
    for (int i = 0; i < 8; i++) cpu_write(2'd0, 8'h11 + 8'(i));
    cpu_write(2'd0, 8'h99);
    cpu_read(2'd2);
    cpu_read(2'd1);
    tx_ready = 1;
    tick(12);
    tx_ready = 0;
    cpu_write(2'd1, 8'h10);

    // RX pushes, reads, underflow and sticky clear
    tick(1); rx_valid = 1; rx_data = 8'hA5;
    tick(1); rx_data = 8'h5A;
    tick(1); rx_valid = 0;
    repeat (3) cpu_read(2'd0);
    cpu_read(2'd1);
    cpu_write(2'd1, 8'h20);
    cpu_read(2'd1);
    rx_valid = 1;
    for (int i = 0; i < 10; i++) begin rx_data = 8'($urandom); tick(1); end
    rx_valid = 0;
    cpu_read(2'd1);
    repeat (9) cpu_read(2'd0);
    cpu_write(2'd1, 8'h30);

    // Interrupts
    cpu_write(2'd3, 8'h01);
    tick(3);
    rx_valid = 1; rx_data = 8'h77; tick(1); rx_valid = 0;
    tick(3);
    cpu_read(2'd0);
    tick(3);
    cpu_write(2'd3, 8'h02);
    tick(3);
    cpu_read(2'd3);
    cpu_write(2'd3, 8'hFC);

    // Back-to-back reads against continuous RX traffic, across pointer wrap
    fab_mode = 2;
    repeat (24) cpu_read(2'd0);
    fab_mode = 0;
    tick(1); rx_valid = 0; tx_ready = 0;

    // Random mix
    fab_mode = 1;
    repeat (150) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) cpu_write(r == 0 ? 2'($urandom) : 2'd0, 8'($urandom), $urandom_range(0, 9) == 0);
      else if (r < 9) cpu_read(r < 7 ? 2'd0 : 2'($urandom));
      else tick($urandom_range(1, 3));
    end
    fab_mode = 0;
    tick(1); rx_valid = 0; tx_ready = 1;
    tick(12);
    tx_ready = 0;

    // Reset during the WAIT cycle of a DATA read
    do_reset();
    tick(1); rx_valid = 1; rx_data = 8'h3C;
    tick(1); rx_valid = 0;
    xm_cs = 1; xm_oe = 1; xm_we = 0; xm_adr = 2'd0;
    tick(1);
    rst = 1; xm_cs = 0; xm_oe = 0;
    tick(2);
    rst = 0;
    cpu_read(2'd2);
    cpu_read(2'd1);
    tick(4);
    chk("rd_q_empty", exp_rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
